// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier: WL x WL -> 2*WL, one partial product per clock.
// Define SIGNED_MUL_EN to treat operands and product as two's complement.
module shift_add_multiplier #(
    parameter int WL = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [WL-1:0]   multiplicand,
    input  logic [WL-1:0]   multiplier,
    output logic            busy,
    output logic            done,
    output logic [2*WL-1:0] product
);

    localparam int CW = $clog2(WL) + 1;
    localparam logic [CW-1:0] LAST = CW'(WL - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WL-1:0]   a_q, a_d;
    logic [WL-1:0]   accHi_q, accHi_d;
    logic [WL-1:0]   accLo_q, accLo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*WL-1:0] product_q, product_d;
    logic [WL:0]     sum;
    logic [2*WL-1:0] shifted;
    logic [WL-1:0]   capA, capB;
`ifdef SIGNED_MUL_EN
    logic            neg_q, neg_d;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    // One shift-add step: the carry out of the adder becomes the new MSB.
    always_comb begin
        sum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, a_q} : {(WL+1){1'b0}});
        shifted = {sum, accLo_q[WL-1:1]};
    end

`ifdef SIGNED_MUL_EN
    always_comb begin
        capA = multiplicand[WL-1] ? -multiplicand : multiplicand;
        capB = multiplier[WL-1]   ? -multiplier   : multiplier;
    end
`else
    always_comb begin
        capA = multiplicand;
        capB = multiplier;
    end
`endif

    // The product register is loaded on the final CALC edge so it is valid during the done pulse.
    always_comb begin
        a_d       = a_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SIGNED_MUL_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = capA;
                    accLo_d = capB;
                    accHi_d = '0;
                    cnt_d   = '0;
`ifdef SIGNED_MUL_EN
                    neg_d   = multiplicand[WL-1] ^ multiplier[WL-1];
`endif
                end
            end
            CALC: begin
                accHi_d = shifted[2*WL-1:WL];
                accLo_d = shifted[WL-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
`ifdef SIGNED_MUL_EN
                    product_d = neg_q ? -shifted : shifted;
`else
                    product_d = shifted;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q       <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SIGNED_MUL_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            a_q       <= a_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef SIGNED_MUL_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for held start, back-to-back, and mid-operation reset.
module tb_shift_add_multiplier;

    localparam int WL = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            start = 1'b0;
    logic [WL-1:0]   mcand = '0;
    logic [WL-1:0]   mplier = '0;
    logic            busy;
    logic            done;
    logic [2*WL-1:0] product;

    int checks = 0;
    int errors = 0;
    logic [2*WL-1:0] expQ[$];

    typedef struct {
        logic [WL-1:0]   a;
        logic [WL-1:0]   b;
        logic [2*WL-1:0] p;
    } vec_t;
    vec_t vecs[$];

    shift_add_multiplier #(.WL(WL)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Counts busy cycles from the accepting edge until done is seen (bounded).
    task automatic waitDone(output int lat, output int busyN, output bit ok);
        lat   = 0;
        busyN = 0;
        ok    = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (busy) busyN++;
            if (done) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [2*WL-1:0] p);
        @(negedge CLK);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        expQ.push_back(p);
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic checkOutput(input int lat, input int busyN, input bit ok);
        logic [2*WL-1:0] exp;
        check("doneSeen", {31'd0, ok}, 32'd1);
        check("latency", lat, WL + 1);
        check("busyCycles", busyN, WL);
        check("busyAtDone", {31'd0, busy}, 32'd0);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got product %0h, expected queue empty", product);
        end else begin
            exp = expQ.pop_front();
            check("product", {24'd0, product}, {24'd0, exp});
        end
    endtask

    initial begin
        int lat;
        int busyN;
        int doneSeen;
        bit ok;

`ifdef SIGNED_MUL_EN
        vecs.push_back('{4'hD, 4'h5, 8'hF1});
        vecs.push_back('{4'h8, 4'h8, 8'h40});
        vecs.push_back('{4'h7, 4'hF, 8'hF9});
        vecs.push_back('{4'h0, 4'hB, 8'h00});
        vecs.push_back('{4'h8, 4'h7, 8'hC8});
        vecs.push_back('{4'h7, 4'h7, 8'h31});
`else
        vecs.push_back('{4'd13, 4'd11, 8'h8F});
        vecs.push_back('{4'd15, 4'd15, 8'hE1});
        vecs.push_back('{4'd0,  4'd9,  8'h00});
        vecs.push_back('{4'd1,  4'd1,  8'h01});
        vecs.push_back('{4'd15, 4'd0,  8'h00});
        vecs.push_back('{4'd8,  4'd2,  8'h10});
`endif

        repeat (2) @(negedge CLK);
        check("resetBusy", {31'd0, busy}, 32'd0);
        check("resetDone", {31'd0, done}, 32'd0);
        check("resetProduct", {24'd0, product}, 32'd0);
        RST = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p);
            waitDone(lat, busyN, ok);
            checkOutput(lat, busyN, ok);
        end

        // Start held high with operands changing after capture.
        @(negedge CLK);
        mcand  = 4'd5;
        mplier = 4'd3;
        start  = 1'b1;
        expQ.push_back(8'h0F);
        lat   = 0;
        busyN = 0;
        ok    = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            mcand  = 4'($urandom);
            mplier = 4'($urandom);
            if (busy) busyN++;
            if (done) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
        checkOutput(lat, busyN, ok);

        // Start still high in DONE must be ignored; accepted in the following IDLE.
        mcand  = 4'd2;
        mplier = 4'd3;
        @(negedge CLK);
        check("startIgnoredBusy", {31'd0, busy}, 32'd0);
        check("startIgnoredDone", {31'd0, done}, 32'd0);
        expQ.push_back(8'h06);
        @(posedge CLK);
        #1 start = 1'b0;
        check("productHolds", {24'd0, product}, 32'h0F);
        waitDone(lat, busyN, ok);
        checkOutput(lat, busyN, ok);

        // Back-to-back: start in the cycle right after done.
        applyStimulus(4'd3, 4'd3, 8'h09);
        check("productHoldsB2B", {24'd0, product}, 32'h06);
        waitDone(lat, busyN, ok);
        checkOutput(lat, busyN, ok);

        // Reset two cycles into CALC aborts the operation.
        @(negedge CLK);
        mcand  = 4'd5;
        mplier = 4'd5;
        start  = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abortBusy", {31'd0, busy}, 32'd0);
        check("abortDone", {31'd0, done}, 32'd0);
        check("abortProduct", {24'd0, product}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        doneSeen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge CLK);
            if (done) doneSeen++;
        end
        check("noDoneAfterAbort", doneSeen, 0);

        applyStimulus(4'd7, 4'd6, 8'h2A);
        waitDone(lat, busyN, ok);
        checkOutput(lat, busyN, ok);

        check("scoreboardEmpty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
